// File: rtl/sf_pkg.sv
// Shared types and constants for the sf_stream_gen traffic source:
// pattern mode and FSM state enums, plus the Galois LFSR polynomials.
package sf_pkg;

    typedef enum logic [1:0] {
        SF_MODE_CNT   = 2'd0,
        SF_MODE_LFSR  = 2'd1,
        SF_MODE_CONST = 2'd2
    } sf_mode_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } sf_state_e;

    localparam logic [31:0] SF_POLY_8  = 32'h0000_00B8;
    localparam logic [31:0] SF_POLY_16 = 32'h0000_B400;
    localparam logic [31:0] SF_POLY_32 = 32'h8020_0003;

    // Right-shift Galois tap mask for a given word width.
    function automatic logic [31:0] lfsr_poly(input int width);
        case (width)
            8:       return SF_POLY_8;
            16:      return SF_POLY_16;
            default: return SF_POLY_32;
        endcase
    endfunction

endpackage

// File: rtl/sf_pattern_gen.sv
// Pattern register for sf_stream_gen. Captures mode/seed at run start,
// reloads from the captured seed at each new channel frame, and steps the
// counter / LFSR / constant pattern on every accepted word.
module sf_pattern_gen
    import sf_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              reload,
    input  logic              advance,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] dat
);

    localparam logic [31:0]       POLY_ALL = lfsr_poly(DATA_W);
    localparam logic [DATA_W-1:0] POLY     = POLY_ALL[DATA_W-1:0];

    logic [1:0]        mode_r;
    logic [DATA_W-1:0] seed_r;
    logic [DATA_W-1:0] pat;

    // An all-zero LFSR state would lock up, so a zero seed starts at 1.
    function automatic logic [DATA_W-1:0] first_word(input logic [1:0] m,
                                                     input logic [DATA_W-1:0] s);
        if (sf_mode_e'(m) == SF_MODE_LFSR && s == '0)
            return DATA_W'(1);
        return s;
    endfunction

    // Capture run settings, reload per channel, or step the pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r <= 2'd0;
            seed_r <= '0;
            pat    <= '0;
        end else if (capture) begin
            mode_r <= mode;
            seed_r <= seed;
            pat    <= first_word(mode, seed);
        end else if (reload) begin
            pat <= first_word(mode_r, seed_r);
        end else if (advance) begin
            case (sf_mode_e'(mode_r))
                SF_MODE_LFSR:  pat <= (pat >> 1) ^ (pat[0] ? POLY : '0);
                SF_MODE_CONST: pat <= pat;
                default:       pat <= pat + DATA_W'(1);
            endcase
        end
    end

    assign dat = pat;

endmodule

// File: rtl/sf_stream_gen.sv
// Start-triggered multi-channel frame source. Each run emits FRAME_LEN
// words per channel (channels 0..NUM_CH-1) separated by GAP_CYCLES idle
// cycles, then pulses done.
// Handshake: a word transfers on a clock edge where req & rdy; while
// req is high and rdy is low, dat/ch/last are held unchanged.
// Optional build macro SF_BACKPRESSURE_TIMEOUT_EN: a stall of TO_CYCLES
// consecutive cycles pulses err and abandons the rest of the frame.
module sf_stream_gen
    import sf_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_CH     = 4,
    parameter int FRAME_LEN  = 64,
    parameter int GAP_CYCLES = 8,
    parameter int TO_CYCLES  = 256
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [1:0]                                  mode,
    input  logic [DATA_W-1:0]                           seed,
    output logic                                        req,
    input  logic                                        rdy,
    output logic [DATA_W-1:0]                           dat,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch,
    output logic                                        last,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        err
);

    localparam int   CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int   IDX_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int   GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic NO_GAP = (GAP_CYCLES == 0);

    sf_state_e         state, state_next;
    logic              start_q;
    logic              start_edge;
    logic              xfer;
    logic              word_last;
    logic              frame_end;
    logic              last_ch;
    logic              gap_end;
    logic              timeout;
    logic              capture, reload, advance;
    logic [CH_W-1:0]   ch_r;
    logic [IDX_W-1:0]  word_idx;
    logic [GAP_W-1:0]  gap_cnt;

    assign start_edge = start & ~start_q;
    assign xfer       = (state == SEND) & rdy;
    assign word_last  = (word_idx == IDX_W'(FRAME_LEN - 1));
    assign last_ch    = (ch_r == CH_W'(NUM_CH - 1));
    assign gap_end    = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign frame_end  = (xfer & word_last) | timeout;

`ifdef SF_BACKPRESSURE_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);
    logic [TO_W-1:0] stall_cnt;

    assign timeout = (state == SEND) & ~rdy & (stall_cnt == TO_W'(TO_CYCLES - 1));

    // Consecutive stalled cycles within the current frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (state == SEND && !rdy && !timeout)
            stall_cnt <= stall_cnt + TO_W'(1);
        else
            stall_cnt <= '0;
    end
`else
    assign timeout = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // FSM next-state logic; start edges outside IDLE are dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_edge) state_next = LOAD;
            LOAD: state_next = SEND;
            SEND: begin
                if (frame_end) begin
                    if (last_ch)
                        state_next = DONE;
                    else if (NO_GAP)
                        state_next = SEND;
                    else
                        state_next = GAP;
                end
            end
            GAP:  if (gap_end) state_next = SEND;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs and pattern-generator controls.
    always_comb begin
        req     = (state == SEND);
        last    = (state == SEND) & word_last;
        busy    = (state != IDLE);
        done    = (state == DONE);
        err     = timeout;
        capture = (state == LOAD);
        advance = xfer;
        reload  = ((state == GAP) & gap_end) |
                  ((state == SEND) & frame_end & ~last_ch & NO_GAP);
    end

    // Start edge detector, channel / word / gap counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q  <= 1'b0;
            ch_r     <= '0;
            word_idx <= '0;
            gap_cnt  <= '0;
        end else begin
            start_q <= start;
            gap_cnt <= (state == GAP && !gap_end) ? gap_cnt + GAP_W'(1) : '0;
            case (state)
                LOAD: begin
                    ch_r     <= '0;
                    word_idx <= '0;
                end
                SEND: begin
                    if (frame_end) begin
                        word_idx <= '0;
                        if (!last_ch && NO_GAP)
                            ch_r <= ch_r + CH_W'(1);
                    end else if (xfer) begin
                        word_idx <= word_idx + IDX_W'(1);
                    end
                end
                GAP: begin
                    if (gap_end)
                        ch_r <= ch_r + CH_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign ch = ch_r;

    sf_pattern_gen #(.DATA_W(DATA_W)) u_pattern (
        .clk     (clk),
        .rst     (rst),
        .capture (capture),
        .reload  (reload),
        .advance (advance),
        .mode    (mode),
        .seed    (seed),
        .dat     (dat)
    );

endmodule

// File: tb/tb_sf_stream_gen.sv
// Bench for sf_stream_gen (DATA_W=16, NUM_CH=2, FRAME_LEN=4, GAP=2, TO=8).
// Honors SF_BACKPRESSURE_TIMEOUT_EN for the stall scenario.
module tb_sf_stream_gen;

    localparam int DATA_W     = 16;
    localparam int NUM_CH     = 2;
    localparam int FRAME_LEN  = 4;
    localparam int GAP_CYCLES = 2;
    localparam int TO_CYCLES  = 8;
    localparam int EW         = DATA_W + 2;
    localparam int RUN_LEN    = 2 + NUM_CH * FRAME_LEN + (NUM_CH - 1) * GAP_CYCLES + 1;

    logic              clk;
    logic              rst;
    logic              start;
    logic [1:0]        mode;
    logic [DATA_W-1:0] seed;
    logic              req;
    logic              rdy;
    logic [DATA_W-1:0] dat;
    logic [0:0]        ch;
    logic              last;
    logic              busy;
    logic              done;
    logic              err;

    int checks   = 0;
    int failures = 0;

    logic [EW-1:0] exp_q[$];

    sf_stream_gen #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .FRAME_LEN(FRAME_LEN),
        .GAP_CYCLES(GAP_CYCLES), .TO_CYCLES(TO_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
        .req(req), .rdy(rdy), .dat(dat), .ch(ch), .last(last),
        .busy(busy), .done(done), .err(err)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    // Reference word list for one run: every channel restarts from the seed.
    task automatic build_expected(input logic [1:0] m, input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] v;
        exp_q.delete();
        for (int c = 0; c < NUM_CH; c++) begin
            v = s;
            if (m == 2'd1 && v == '0) v = 16'h0001;
            for (int k = 0; k < FRAME_LEN; k++) begin
                exp_q.push_back({(k == FRAME_LEN - 1), 1'(c), v});
                case (m)
                    2'd1:    v = lfsr_next(v);
                    2'd2:    v = v;
                    default: v = v + 16'd1;
                endcase
            end
        end
    endtask

    // One full run. rdy_kind: 0=always 1, 1=pattern 1,0,0, 2=random.
    // hold keeps start high throughout; edge_at>0 adds a second edge mid-run.
    task automatic do_run(input logic [1:0] m, input logic [DATA_W-1:0] s,
                          input int rdy_kind, input bit hold, input int edge_at);
        int cyc;
        int done_at;
        int first_req;
        int ndone;
        logic [EW-1:0] obs;
        build_expected(m, s);
        mode = m;
        seed = s;
        start = 1'b1;
        cyc = 0;
        done_at = -1;
        first_req = -1;
        ndone = 0;
        while (cyc < 2000) begin
            if (cyc == 1 && !hold) start = 1'b0;
            if (edge_at > 0 && cyc == edge_at) start = 1'b0;
            if (edge_at > 0 && cyc == edge_at + 1) start = 1'b1;
            if (cyc >= 2) begin
                mode = 2'($urandom);
                seed = 16'($urandom);
            end
            case (rdy_kind)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            #1;
            obs = {last, ch, dat};
            if (req) begin
                if (first_req < 0) first_req = cyc;
                if (exp_q.size() == 0) begin
                    chk("extra_word", 64'(obs), 64'(0));
                end else begin
                    chk("word", 64'(obs), 64'(exp_q[0]));
                    if (rdy) void'(exp_q.pop_front());
                end
            end
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = cyc;
            end
            chk("busy", 64'(busy), 64'(cyc >= 1 && (done_at < 0 || cyc <= done_at)));
            if (done_at >= 0 && cyc > done_at) chk("req_after_done", 64'(req), 64'(0));
`ifndef SF_BACKPRESSURE_TIMEOUT_EN
            chk("err_idle", 64'(err), 64'(0));
`endif
            next_cycle();
            cyc++;
            if (done_at >= 0 && cyc > done_at + 6) break;
        end
        chk("run_finished", 64'(done_at >= 0), 64'(1));
        chk("done_pulses", 64'(ndone), 64'(1));
        chk("words_left", 64'(exp_q.size()), 64'(0));
        if (rdy_kind == 0) begin
            chk("first_req_latency", 64'(first_req), 64'(2));
            chk("run_length", 64'(done_at + 1), 64'(RUN_LEN));
        end
        start = 1'b0;
        rdy = 1'b0;
        next_cycle();
    endtask

    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_req", 64'(req), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ch", 64'(ch), 64'(0));
        chk("rst_last", 64'(last), 64'(0));
        chk("rst_dat", 64'(dat), 64'(0));
        start = 1'b0;
        rdy = 1'b0;
        next_cycle();
        chk("rst_no_done", 64'(done), 64'(0));
        rst = 1'b0;
        next_cycle();
    endtask

    // Directed sequence of scenarios.
    initial begin
        rst = 1'b1;
        start = 1'b0;
        mode = 2'd0;
        seed = '0;
        rdy = 1'b0;
        #2;
        chk("reset_req", 64'(req), 64'(0));
        chk("reset_dat", 64'(dat), 64'(0));
        chk("reset_ch", 64'(ch), 64'(0));
        chk("reset_last", 64'(last), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_err", 64'(err), 64'(0));
        #20;
        rst = 1'b0;
        next_cycle();

        do_run(2'd0, 16'h0010, 0, 1'b0, 0);
        do_run(2'd0, 16'($urandom), 1, 1'b0, 0);
        do_run(2'd1, 16'h0000, 0, 1'b0, 0);
        do_run(2'd0, 16'hFFFE, 0, 1'b0, 0);
        do_run(2'd2, 16'($urandom), 2, 1'b0, 0);
        do_run(2'd3, 16'($urandom), 2, 1'b0, 0);
        do_run(2'd1, 16'($urandom), 2, 1'b0, 0);
        do_run(2'd1, 16'($urandom), 1, 1'b0, 0);
        do_run(2'd0, 16'($urandom), 0, 1'b1, 5);

        // Sustained back-pressure on channel 0.
        mode = 2'd0;
        seed = 16'h0042;
        start = 1'b1;
        rdy = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc == 1) start = 1'b0;
            #1;
`ifdef SF_BACKPRESSURE_TIMEOUT_EN
            if (cyc >= 2 && cyc <= 9) begin
                chk("stall_req", 64'(req), 64'(1));
                chk("stall_err", 64'(err), 64'(cyc == 9));
            end
            if (cyc == 10 || cyc == 11) chk("timeout_gap", 64'(req), 64'(0));
            if (cyc == 12) begin
                chk("timeout_next_req", 64'(req), 64'(1));
                chk("timeout_next_ch", 64'(ch), 64'(1));
                chk("timeout_next_dat", 64'(dat), 64'(16'h0042));
            end
`else
            if (cyc >= 2) begin
                chk("stall_req", 64'(req), 64'(1));
                chk("stall_dat", 64'(dat), 64'(16'h0042));
                chk("stall_ch", 64'(ch), 64'(0));
                chk("stall_err", 64'(err), 64'(0));
            end
`endif
            next_cycle();
        end
        pulse_reset();

        // Reset mid-frame, then a clean run from channel 0.
        mode = 2'd0;
        seed = 16'h1234;
        start = 1'b1;
        rdy = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (4) next_cycle();
        pulse_reset();
        do_run(2'd0, 16'h0100, 0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
